// File: rtl/resc_pkg.sv
// Shared definitions for the ReSC stream sequencer: controller states and
// default datapath widths.
package resc_pkg;

    localparam int RESC_LFSR_WIDTH = 10;
    localparam int RESC_CNT_WIDTH  = RESC_LFSR_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } resc_seq_state_t;

endpackage

// File: rtl/resc_stream_sequencer.sv
// Runs one stochastic-computing evaluation: seeds and enables the LFSR for a
// programmed stream length, counts ones in the ReSC bitstream, hands back the count.
module resc_stream_sequencer
    import resc_pkg::*;
#(
    parameter int LFSR_WIDTH = RESC_LFSR_WIDTH,
    parameter int CNT_WIDTH  = LFSR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LFSR_WIDTH-1:0] seed_in,
    input  logic [LFSR_WIDTH-1:0] len_in,
    input  logic                  abort,
    input  logic                  sc_bit,
    output logic [LFSR_WIDTH-1:0] lfsr_seed,
    output logic                  lfsr_restart,
    output logic                  lfsr_enable,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  result,
    output logic                  result_valid,
    input  logic                  result_ready
);

    // A zero length selects the full added-zero period.
    localparam logic [CNT_WIDTH-1:0] FULL_LEN = CNT_WIDTH'(1) << LFSR_WIDTH;

    resc_seq_state_t       state_q, state_d;
    logic [LFSR_WIDTH-1:0] seed_q, seed_d;
    logic [CNT_WIDTH-1:0]  target_q, target_d;
    logic [CNT_WIDTH-1:0]  len_cnt_q, len_cnt_d;
    logic [CNT_WIDTH-1:0]  ones_q, ones_d;
    logic [CNT_WIDTH-1:0]  result_q, result_d;
    logic                  result_valid_q, result_valid_d;
    logic [CNT_WIDTH-1:0]  len_cnt_inc;
    logic [CNT_WIDTH-1:0]  ones_inc;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path infers a latch.
        state_d        = state_q;
        seed_d         = seed_q;
        target_d       = target_q;
        len_cnt_d      = len_cnt_q;
        ones_d         = ones_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        len_cnt_inc    = len_cnt_q + CNT_WIDTH'(1);
        ones_inc       = ones_q + CNT_WIDTH'(sc_bit);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    seed_d    = seed_in;
                    target_d  = (len_in == '0) ? FULL_LEN : CNT_WIDTH'(len_in);
                    len_cnt_d = '0;
                    ones_d    = '0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                len_cnt_d = len_cnt_inc;
                ones_d    = ones_inc;
                // Abort beats completion when both land on the last sample.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (len_cnt_inc == target_q) begin
                    result_d       = ones_inc;
                    result_valid_d = 1'b1;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            seed_q         <= '0;
            target_q       <= '0;
            len_cnt_q      <= '0;
            ones_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            seed_q         <= seed_d;
            target_q       <= target_d;
            len_cnt_q      <= len_cnt_d;
            ones_q         <= ones_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign lfsr_seed    = seed_q;
    assign lfsr_restart = (state_q == ST_LOAD);
    assign lfsr_enable  = (state_q == ST_RUN);
    assign busy         = (state_q == ST_LOAD) || (state_q == ST_RUN);
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_resc_stream_sequencer.sv
// Directed bench for resc_stream_sequencer with a behavioural added-zero LFSR
// driving sc_bit in the model-based scenario.
module tb_resc_stream_sequencer;

    localparam int W = 10;
    localparam int C = 11;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] seed_in = '0;
    logic [W-1:0] len_in = '0;
    logic         abort = 1'b0;
    logic         sc_bit;
    logic [W-1:0] lfsr_seed;
    logic         lfsr_restart;
    logic         lfsr_enable;
    logic         busy;
    logic [C-1:0] result;
    logic         result_valid;
    logic         result_ready = 1'b1;

    logic         sc_const = 1'b1;
    logic         use_model = 1'b0;
    logic [W-1:0] lfsr_q;

    int vectors = 0;
    int miscompares = 0;

    resc_stream_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .seed_in      (seed_in),
        .len_in       (len_in),
        .abort        (abort),
        .sc_bit       (sc_bit),
        .lfsr_seed    (lfsr_seed),
        .lfsr_restart (lfsr_restart),
        .lfsr_enable  (lfsr_enable),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    // Fibonacci x^10+x^7+1 with the all-zero state spliced in (de Bruijn).
    always @(posedge clk or posedge reset) begin
        if (reset) lfsr_q <= '0;
        else if (lfsr_restart) lfsr_q <= lfsr_seed;
        else if (lfsr_enable) lfsr_q <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6] ^ (lfsr_q[8:0] == 9'd0)};
    end

    assign sc_bit = use_model ? (lfsr_q < 10'd256) : sc_const;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts one evaluation and follows it until result_valid or the budget runs out.
    // start is re-pulsed on loop iteration poke (negative: never).
    task automatic run_eval(input logic [W-1:0] seed, input logic [W-1:0] len, input int poke,
                            output int cyc, output int en_cnt, output int rs_cnt);
        seed_in = seed;
        len_in  = len;
        start   = 1'b1;
        tick();
        start  = 1'b0;
        cyc    = 0;
        en_cnt = 0;
        rs_cnt = 0;
        while (!result_valid && cyc < 2000) begin
            if (lfsr_restart) rs_cnt++;
            if (lfsr_enable) en_cnt++;
            start = (cyc == poke);
            tick();
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        vectors++;
        if ({lfsr_seed, lfsr_restart, lfsr_enable, busy, result, result_valid} !== '0) begin
            miscompares++;
            $display("FAIL %s: seed=%h rs=%b en=%b busy=%b result=%0d valid=%b, required all zero",
                     tag, lfsr_seed, lfsr_restart, lfsr_enable, busy, result, result_valid);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        check_idle_outputs("reset_values");
        reset = 1'b0;
        tick();
        check_idle_outputs("idle_after_reset");
    endtask

    task automatic test_basic();
        int cyc, en, rs;
        sc_const = 1'b1;
        run_eval(10'h001, 10'd4, -1, cyc, en, rs);
        vectors++;
        if (cyc !== 5) begin miscompares++; $display("FAIL basic_latency: got %0d expected 5", cyc); end
        vectors++;
        if (rs !== 1) begin miscompares++; $display("FAIL basic_restart_cycles: got %0d expected 1", rs); end
        vectors++;
        if (en !== 4) begin miscompares++; $display("FAIL basic_enable_cycles: got %0d expected 4", en); end
        vectors++;
        if (result !== 11'd4) begin miscompares++; $display("FAIL basic_result: got %0d expected 4", result); end
        vectors++;
        if (lfsr_seed !== 10'h001) begin miscompares++; $display("FAIL basic_seed: got %h expected 001", lfsr_seed); end
        tick();
        vectors++;
        if ({result_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL basic_back_to_idle: valid=%b busy=%b expected 0 0", result_valid, busy);
        end
    endtask

    task automatic test_full_length();
        int cyc, en, rs;
        sc_const = 1'b1;
        run_eval(10'h155, 10'd0, -1, cyc, en, rs);
        vectors++;
        if (en !== 1024) begin miscompares++; $display("FAIL full_enable_cycles: got %0d expected 1024", en); end
        vectors++;
        if (result !== 11'd1024) begin miscompares++; $display("FAIL full_result: got %0d expected 1024", result); end
        vectors++;
        if (cyc !== 1025) begin miscompares++; $display("FAIL full_latency: got %0d expected 1025", cyc); end
        tick();
    endtask

    task automatic test_lfsr_model();
        int cyc, en, rs;
        use_model = 1'b1;
        run_eval(10'h2A5, 10'd0, -1, cyc, en, rs);
        vectors++;
        if (result !== 11'd256) begin miscompares++; $display("FAIL model_full_period: got %0d expected 256", result); end
        tick();
        // Samples 0x200 (no), 0x000, 0x001, 0x002: the seed itself is the first sample.
        run_eval(10'h200, 10'd4, -1, cyc, en, rs);
        vectors++;
        if (result !== 11'd3) begin miscompares++; $display("FAIL model_first_sample_seed: got %0d expected 3", result); end
        tick();
        use_model = 1'b0;
    endtask

    task automatic test_hold_done();
        int cyc, en, rs;
        logic stable;
        sc_const     = 1'b1;
        result_ready = 1'b0;
        run_eval(10'h0F0, 10'd2, -1, cyc, en, rs);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            start   = (i == 5);
            abort   = (i == 9);
            seed_in = 10'h3FF;
            tick();
            if (!result_valid || result !== 11'd2 || busy || lfsr_restart || lfsr_enable) stable = 1'b0;
        end
        start = 1'b0;
        abort = 1'b0;
        vectors++;
        if (stable !== 1'b1) begin
            miscompares++;
            $display("FAIL done_hold: valid=%b result=%0d busy=%b, required valid 1 result 2 busy 0",
                     result_valid, result, busy);
        end
        result_ready = 1'b1;
        start        = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if ({result_valid, busy, lfsr_restart} !== 3'b000) begin
            miscompares++;
            $display("FAIL done_release_start_ignored: valid=%b busy=%b rs=%b expected 0 0 0",
                     result_valid, busy, lfsr_restart);
        end
        tick();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL done_start_stays_ignored: busy=%b expected 0", busy); end
    endtask

    task automatic test_abort();
        int cyc, en, rs;
        logic seen_valid;
        sc_const = 1'b1;
        seed_in  = 10'h010;
        len_in   = 10'd8;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        vectors++;
        if (lfsr_enable !== 1'b1) begin miscompares++; $display("FAIL abort_in_run: en=%b expected 1", lfsr_enable); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if ({busy, lfsr_enable, result_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL abort_to_idle: busy=%b en=%b valid=%b expected 0 0 0", busy, lfsr_enable, result_valid);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (result_valid) seen_valid = 1'b1;
        end
        vectors++;
        if (seen_valid !== 1'b0) begin miscompares++; $display("FAIL abort_no_result: valid seen=%b expected 0", seen_valid); end
        run_eval(10'h020, 10'd3, -1, cyc, en, rs);
        vectors++;
        if (result !== 11'd3 || cyc !== 4) begin
            miscompares++;
            $display("FAIL abort_then_start: result=%0d latency=%0d expected 3 and 4", result, cyc);
        end
        tick();
        // Abort coinciding with the final RUN cycle must not reach DONE.
        len_in = 10'd2;
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if ({result_valid, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_last_cycle: valid=%b busy=%b expected 0 0", result_valid, busy);
        end
    endtask

    task automatic test_start_in_run();
        int cyc, en, rs;
        sc_const = 1'b1;
        run_eval(10'h0AA, 10'd6, 3, cyc, en, rs);
        vectors++;
        if (rs !== 1 || en !== 6 || result !== 11'd6) begin
            miscompares++;
            $display("FAIL start_in_run_ignored: restarts=%0d enables=%0d result=%0d expected 1 6 6", rs, en, result);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        int cyc, en, rs;
        sc_const = 1'b1;
        seed_in  = 10'h3C3;
        len_in   = 10'd8;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("reset_mid_run_async");
        tick();
        reset = 1'b0;
        tick();
        check_idle_outputs("reset_mid_run_idle");
        run_eval(10'h3C3, 10'd5, -1, cyc, en, rs);
        vectors++;
        if (result !== 11'd5 || cyc !== 6) begin
            miscompares++;
            $display("FAIL after_reset_run: result=%0d latency=%0d expected 5 and 6", result, cyc);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_length();
        test_lfsr_model();
        test_hold_done();
        test_abort();
        test_start_in_run();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
